// File: rtl/axi4_mem_tester_pkg.sv
// Shared definitions for the AXI4 memory tester.
//   state_e  : sequencing states of the tester FSM
//   step()   : byte distance between consecutive burst start addresses
//   pattern(): expected data word for a beat address
// The functions operate on 64-bit containers so that they stay independent of
// the tester's width parameters. Callers cast the result down to their width.
package axi4_mem_tester_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        AR   = 3'd4,
        R    = 3'd5,
        END  = 3'd6
    } state_e;

    // Bytes covered by one burst of burst_len+1 beats of dw bits.
    function automatic int unsigned step(input logic [7:0] burst_len, input int unsigned dw);
        return (32'(burst_len) + 32'd1) * dw / 32'd8;
    endfunction

    // Address truncated/zero-extended to dw bits, XORed with the seed, and
    // optionally inverted. Bits at and above dw are always 0.
    function automatic logic [63:0] pattern(input logic [63:0] addr,
                                            input logic [63:0] seed,
                                            input logic        invert,
                                            input int unsigned dw);
        logic [63:0] mask;
        logic [63:0] p;
        mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
        p    = (addr ^ seed) & mask;
        if (invert) begin
            p = ~p & mask;
        end
        return p;
    endfunction

endpackage

// File: rtl/axi4_mem_tester.sv
// Self-checking AXI4 master: writes an address-derived pattern over a region
// of NUM_BURSTS bursts, reads it back and compares every beat.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   start, loop         run request (IDLE only), continue-after-pass request
//   busy, done          run in progress, one-cycle end-of-pass pulse
//   pass_cnt, err_cnt   completed passes (wraps), data mismatches (saturates)
//   first_err_addr      byte address of the first mismatch in the run
//   proto_err           sticky rlast misplacement flag
//   aw*/w*/b*/ar*/r*    AXI4 master channels, one transaction outstanding
//
// state | meaning
// IDLE  | waiting for start
// AW    | write address presented, waiting for awready
// W     | streaming BURST_LEN+1 write beats
// B     | waiting for the write response
// AR    | read address presented, waiting for arready
// R     | receiving and checking BURST_LEN+1 read beats
// END   | one-cycle end of pass, done asserted
module axi4_mem_tester
    import axi4_mem_tester_pkg::*;
#(
    parameter int unsigned          A_WIDTH    = 25,
    parameter int unsigned          D_WIDTH    = 16,
    parameter logic [7:0]           BURST_LEN  = 8'd15,
    parameter logic [A_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int unsigned          NUM_BURSTS = 16,
    parameter logic [D_WIDTH-1:0]   SEED       = '1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               start,
    input  logic               loop,
    output logic               busy,
    output logic               done,
    output logic [15:0]        pass_cnt,
    output logic [15:0]        err_cnt,
    output logic [A_WIDTH-1:0] first_err_addr,
    output logic               proto_err,
    output logic               awvalid,
    input  logic               awready,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic               wvalid,
    input  logic               wready,
    output logic               wlast,
    output logic [D_WIDTH-1:0] wdata,
    input  logic               bvalid,
    output logic               bready,
    output logic               arvalid,
    input  logic               arready,
    output logic [A_WIDTH-1:0] araddr,
    output logic [7:0]         arlen,
    input  logic               rvalid,
    output logic               rready,
    input  logic               rlast,
    input  logic [D_WIDTH-1:0] rdata
);

    localparam logic [A_WIDTH-1:0] BYTES_A    = A_WIDTH'(D_WIDTH / 8);
    localparam logic [A_WIDTH-1:0] STEP_A     = A_WIDTH'(step(BURST_LEN, D_WIDTH));
    localparam int unsigned        BI_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BI_W-1:0]    LAST_BURST = BI_W'(NUM_BURSTS - 1);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [15:0]        pass_cnt_q;
    logic [15:0]        err_cnt_q;
    logic [A_WIDTH-1:0] first_err_addr_q;
    logic               err_seen_q;
    logic               proto_err_q;
    logic               awvalid_q;
    logic [A_WIDTH-1:0] awaddr_q;
    logic               wvalid_q;
    logic               wlast_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic               bready_q;
    logic               arvalid_q;
    logic [A_WIDTH-1:0] araddr_q;
    logic               rready_q;
    logic [BI_W-1:0]    burst_q;
    logic [7:0]         beat_q;
    logic [A_WIDTH-1:0] burst_addr_q;
    logic [A_WIDTH-1:0] beat_addr_q;

    logic [A_WIDTH-1:0] burst_addr_d;
    logic [A_WIDTH-1:0] beat_addr_d;
    logic [D_WIDTH-1:0] wdata_first_d;
    logic [D_WIDTH-1:0] wdata_next_d;
    logic [D_WIDTH-1:0] rdata_exp_d;

    // Pattern polarity follows pass_cnt[0], so a looped pass sees the
    // already-incremented count and writes the inverted pattern.
    always_comb begin
        burst_addr_d  = burst_addr_q + STEP_A;
        beat_addr_d   = beat_addr_q + BYTES_A;
        wdata_first_d = D_WIDTH'(pattern(64'(burst_addr_q), 64'(SEED), pass_cnt_q[0], D_WIDTH));
        wdata_next_d  = D_WIDTH'(pattern(64'(beat_addr_d), 64'(SEED), pass_cnt_q[0], D_WIDTH));
        rdata_exp_d   = D_WIDTH'(pattern(64'(beat_addr_q), 64'(SEED), pass_cnt_q[0], D_WIDTH));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q          <= IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_cnt_q       <= '0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            err_seen_q       <= 1'b0;
            proto_err_q      <= 1'b0;
            awvalid_q        <= 1'b0;
            awaddr_q         <= '0;
            wvalid_q         <= 1'b0;
            wlast_q          <= 1'b0;
            wdata_q          <= '0;
            bready_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            araddr_q         <= '0;
            rready_q         <= 1'b0;
            burst_q          <= '0;
            beat_q           <= '0;
            burst_addr_q     <= '0;
            beat_addr_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_cnt_q        <= '0;
                        first_err_addr_q <= '0;
                        err_seen_q       <= 1'b0;
                        proto_err_q      <= 1'b0;
                        busy_q           <= 1'b1;
                        burst_q          <= '0;
                        burst_addr_q     <= BASE_ADDR;
                        awaddr_q         <= BASE_ADDR;
                        awvalid_q        <= 1'b1;
                        state_q          <= AW;
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b1;
                        wdata_q     <= wdata_first_d;
                        wlast_q     <= (BURST_LEN == 8'd0);
                        beat_q      <= '0;
                        beat_addr_q <= burst_addr_q;
                        state_q     <= W;
                    end
                end
                W: begin
                    if (wready) begin
                        if (beat_q == BURST_LEN) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= B;
                        end else begin
                            beat_q      <= beat_q + 8'd1;
                            beat_addr_q <= beat_addr_d;
                            wdata_q     <= wdata_next_d;
                            wlast_q     <= ((beat_q + 8'd1) == BURST_LEN);
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        if (burst_q == LAST_BURST) begin
                            burst_q      <= '0;
                            burst_addr_q <= BASE_ADDR;
                            araddr_q     <= BASE_ADDR;
                            arvalid_q    <= 1'b1;
                            state_q      <= AR;
                        end else begin
                            burst_q      <= burst_q + 1'b1;
                            burst_addr_q <= burst_addr_d;
                            awaddr_q     <= burst_addr_d;
                            awvalid_q    <= 1'b1;
                            state_q      <= AW;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q   <= 1'b0;
                        rready_q    <= 1'b1;
                        beat_q      <= '0;
                        beat_addr_q <= burst_addr_q;
                        state_q     <= R;
                    end
                end
                R: begin
                    if (rvalid && rready_q) begin
                        if (rdata != rdata_exp_d) begin
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                            if (!err_seen_q) begin
                                first_err_addr_q <= beat_addr_q;
                                err_seen_q       <= 1'b1;
                            end
                        end
                        if (rlast != (beat_q == BURST_LEN)) begin
                            proto_err_q <= 1'b1;
                        end
                        // Beat count alone terminates the burst; rlast only
                        // feeds the protocol check.
                        if (beat_q == BURST_LEN) begin
                            rready_q <= 1'b0;
                            if (burst_q == LAST_BURST) begin
                                done_q     <= 1'b1;
                                pass_cnt_q <= pass_cnt_q + 16'd1;
                                state_q    <= END;
                            end else begin
                                burst_q      <= burst_q + 1'b1;
                                burst_addr_q <= burst_addr_d;
                                araddr_q     <= burst_addr_d;
                                arvalid_q    <= 1'b1;
                                state_q      <= AR;
                            end
                        end else begin
                            beat_q      <= beat_q + 8'd1;
                            beat_addr_q <= beat_addr_d;
                        end
                    end
                end
                END: begin
                    if (loop) begin
                        burst_q      <= '0;
                        burst_addr_q <= BASE_ADDR;
                        awaddr_q     <= BASE_ADDR;
                        awvalid_q    <= 1'b1;
                        state_q      <= AW;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign proto_err      = proto_err_q;
    assign awvalid        = awvalid_q;
    assign awaddr         = awaddr_q;
    assign awlen          = BURST_LEN;
    assign wvalid         = wvalid_q;
    assign wlast          = wlast_q;
    assign wdata          = wdata_q;
    assign bready         = bready_q;
    assign arvalid        = arvalid_q;
    assign araddr         = araddr_q;
    assign arlen          = BURST_LEN;
    assign rready         = rready_q;

endmodule

// File: tb/tb_axi4_mem_tester.sv
module tb_axi4_mem_tester;

    logic        aclk = 1'b0;
    logic        areset, start, loop;
    logic        busy, done, proto_err;
    logic [15:0] pass_cnt, err_cnt;
    logic [24:0] first_err_addr, awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [15:0] wdata, rdata;

    axi4_mem_tester #(
        .A_WIDTH(25), .D_WIDTH(16), .BURST_LEN(8'd3), .BASE_ADDR(25'd0),
        .NUM_BURSTS(2), .SEED(16'hA5A5)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start), .loop(loop),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .proto_err(proto_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // memory responder controls and observations
    bit          stall_en = 0;
    bit          bad_rlast = 0;
    logic [15:0] cor_a = 16'hFFFF, cor_b = 16'hFFFF;
    logic [15:0] mem [0:255];
    logic [24:0] aw_log [0:7];
    logic [24:0] ar_log [0:7];
    logic [15:0] w2_v [0:3];
    int aw_n, ar_n, w2_n, wdata_bad, wlast_bad, stab_chk, stab_bad, r_beats, w_hs;
    int done_seen = 0, model_pass = 0;

    bit          aw_pend, w_pend, b_pend, ar_pend, r_pend;
    logic [24:0] aw_cap, ar_cap, aw_prev;
    logic [15:0] w_cap, w_prev, wr_addr, rd_addr, wa, we, ra;
    logic        w_cap_last, w_prev_last;
    bit          aw_seen, w_seen, b_seen, ar_seen, b_wait, r_act, aw_hold, w_hold;
    int          aw_st, w_st, b_st, ar_st, wbeat, rbeat;

    task automatic clear_logs();
        aw_n = 0; ar_n = 0; w2_n = 0; wdata_bad = 0; wlast_bad = 0;
        stab_chk = 0; stab_bad = 0; r_beats = 0; w_hs = 0;
        for (int i = 0; i < 8; i++) begin
            aw_log[i] = '1;
            ar_log[i] = '1;
        end
        for (int i = 0; i < 4; i++) w2_v[i] = '1;
    endtask

    // Always-ready (or randomly stalled) memory. Decisions are made 1 time
    // unit after each rising edge; handshakes decided here complete at the
    // following edge and are booked at the next step.
    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0;
        rvalid = 0; rlast = 0; rdata = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (areset) begin
                aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
                aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0;
                b_wait = 0; r_act = 0; aw_hold = 0; w_hold = 0;
                wbeat = 0; rbeat = 0; model_pass = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
            end else begin
                if (aw_hold) begin
                    stab_chk++;
                    if (!awvalid || awaddr !== aw_prev) stab_bad++;
                end
                if (w_hold) begin
                    stab_chk++;
                    if (!wvalid || wdata !== w_prev || wlast !== w_prev_last) stab_bad++;
                end
                if (done) begin
                    done_seen++;
                    model_pass++;
                end
                if (aw_pend) begin
                    if (aw_n < 8) aw_log[aw_n] = aw_cap;
                    aw_n++;
                    wr_addr = aw_cap[15:0];
                    wbeat = 0;
                    aw_seen = 0;
                end
                if (w_pend) begin
                    wa = wr_addr + 16'(2 * wbeat);
                    mem[wa[8:1]] = w_cap;
                    we = wa ^ 16'hA5A5 ^ (model_pass[0] ? 16'hFFFF : 16'h0000);
                    if (w_cap !== we) wdata_bad++;
                    if (w_cap_last !== (wbeat == 3)) wlast_bad++;
                    if (wa == 16'd2 && w2_n < 4) begin
                        w2_v[w2_n] = w_cap;
                        w2_n++;
                    end
                    wbeat++;
                    w_hs++;
                    w_seen = 0;
                    if (wbeat == 4) b_wait = 1;
                end
                if (b_pend) begin
                    b_wait = 0;
                    b_seen = 0;
                end
                if (ar_pend) begin
                    if (ar_n < 8) ar_log[ar_n] = ar_cap;
                    ar_n++;
                    rd_addr = ar_cap[15:0];
                    rbeat = 0;
                    r_act = 1;
                    ar_seen = 0;
                end
                if (r_pend) begin
                    rbeat++;
                    r_beats++;
                    if (rbeat == 4) r_act = 0;
                end

                if (awvalid) begin
                    if (!aw_seen) begin aw_seen = 1; aw_st = stall_en ? int'($urandom_range(0, 5)) : 0; end
                    if (aw_st > 0) begin aw_st--; awready = 0; end else awready = 1;
                end else awready = 0;
                if (wvalid) begin
                    if (!w_seen) begin w_seen = 1; w_st = stall_en ? int'($urandom_range(0, 5)) : 0; end
                    if (w_st > 0) begin w_st--; wready = 0; end else wready = 1;
                end else wready = 0;
                if (b_wait) begin
                    if (!b_seen) begin b_seen = 1; b_st = stall_en ? int'($urandom_range(0, 5)) : 0; end
                    if (b_st > 0) begin b_st--; bvalid = 0; end else bvalid = 1;
                end else bvalid = 0;
                if (arvalid) begin
                    if (!ar_seen) begin ar_seen = 1; ar_st = stall_en ? int'($urandom_range(0, 5)) : 0; end
                    if (ar_st > 0) begin ar_st--; arready = 0; end else arready = 1;
                end else arready = 0;
                rvalid = r_act;
                if (r_act) begin
                    ra = rd_addr + 16'(2 * rbeat);
                    rdata = (ra == cor_a || ra == cor_b) ? 16'h0000 : mem[ra[8:1]];
                    rlast = bad_rlast ? (rbeat == 1) : (rbeat == 3);
                end else begin
                    rlast = 0;
                end

                aw_pend = awvalid && awready;  aw_cap = awaddr;
                w_pend  = wvalid && wready;    w_cap = wdata; w_cap_last = wlast;
                b_pend  = bvalid && bready;
                ar_pend = arvalid && arready;  ar_cap = araddr;
                r_pend  = rvalid && rready;
                aw_hold = awvalid && !awready; aw_prev = awaddr;
                w_hold  = wvalid && !wready;   w_prev = wdata; w_prev_last = wlast;
            end
        end
    end

    task automatic start_run();
        start = 1;
        @(posedge aclk);
        #2;
        start = 0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_seen < target && n < 3000) begin
            @(posedge aclk);
            #2;
            n++;
        end
        chk(tag, 32'(done_seen >= target), 32'd1);
    endtask

    task automatic settle();
        repeat (3) @(posedge aclk);
        #2;
    endtask

    int d0;
    int n;

    initial begin
        areset = 1; start = 0; loop = 0;
        clear_logs();
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_bready", 32'(bready), 0);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_awlen", 32'(awlen), 3);
        chk("rst_arlen", 32'(arlen), 3);
        areset = 0;
        @(posedge aclk);
        #2;

        // single clean pass
        clear_logs(); d0 = done_seen;
        start_run();
        wait_done(d0 + 1, "s1_done_timeout");
        settle();
        chk("s1_aw_count", 32'(aw_n), 2);
        chk("s1_awaddr0", 32'(aw_log[0]), 0);
        chk("s1_awaddr1", 32'(aw_log[1]), 8);
        chk("s1_ar_count", 32'(ar_n), 2);
        chk("s1_araddr0", 32'(ar_log[0]), 0);
        chk("s1_araddr1", 32'(ar_log[1]), 8);
        chk("s1_wdata_a2", 32'(w2_v[0]), 32'hA5A7);
        chk("s1_wdata_beats", 32'(wdata_bad), 0);
        chk("s1_wlast_pos", 32'(wlast_bad), 0);
        chk("s1_r_beats", 32'(r_beats), 8);
        chk("s1_err_cnt", 32'(err_cnt), 0);
        chk("s1_pass_cnt", 32'(pass_cnt), 1);
        chk("s1_proto_err", 32'(proto_err), 0);
        chk("s1_done_pulses", 32'(done_seen - d0), 1);
        chk("s1_busy_idle", 32'(busy), 0);

        // fault injection
        clear_logs(); d0 = done_seen; cor_a = 16'd10;
        start_run();
        wait_done(d0 + 1, "s2a_done_timeout");
        settle();
        chk("s2a_err_cnt", 32'(err_cnt), 1);
        chk("s2a_first_err", 32'(first_err_addr), 10);
        chk("s2a_wdata_beats", 32'(wdata_bad), 0);
        clear_logs(); d0 = done_seen; cor_b = 16'd12;
        start_run();
        wait_done(d0 + 1, "s2b_done_timeout");
        settle();
        chk("s2b_err_cnt", 32'(err_cnt), 2);
        chk("s2b_first_err", 32'(first_err_addr), 10);
        chk("s2b_pass_cnt", 32'(pass_cnt), 3);
        chk("s2b_wdata_beats", 32'(wdata_bad), 0);
        cor_a = 16'hFFFF; cor_b = 16'hFFFF;

        // backpressure
        clear_logs(); d0 = done_seen; stall_en = 1;
        start_run();
        wait_done(d0 + 1, "s3_done_timeout");
        settle();
        stall_en = 0;
        chk("s3_stalls_seen", 32'(stab_chk > 0), 1);
        chk("s3_stable", 32'(stab_bad), 0);
        chk("s3_awaddr0", 32'(aw_log[0]), 0);
        chk("s3_awaddr1", 32'(aw_log[1]), 8);
        chk("s3_araddr1", 32'(ar_log[1]), 8);
        chk("s3_wdata_beats", 32'(wdata_bad), 0);
        chk("s3_wlast_pos", 32'(wlast_bad), 0);
        chk("s3_err_cnt", 32'(err_cnt), 0);
        chk("s3_proto_err", 32'(proto_err), 0);
        chk("s3_pass_cnt", 32'(pass_cnt), 4);

        // loop mode from a fresh pass count
        areset = 1;
        repeat (2) @(posedge aclk);
        #2;
        areset = 0;
        chk("s4_pass_cnt_rst", 32'(pass_cnt), 0);
        @(posedge aclk);
        #2;
        clear_logs(); d0 = done_seen; loop = 1;
        start_run();
        wait_done(d0 + 1, "s4_done1_timeout");
        @(posedge aclk);
        #2;
        loop = 0;
        chk("s4_busy_between", 32'(busy), 1);
        wait_done(d0 + 2, "s4_done2_timeout");
        settle();
        chk("s4_w2_count", 32'(w2_n), 2);
        chk("s4_wdata_p0", 32'(w2_v[0]), 32'hA5A7);
        chk("s4_wdata_p1", 32'(w2_v[1]), 32'h5A58);
        chk("s4_pass_cnt", 32'(pass_cnt), 2);
        chk("s4_done_pulses", 32'(done_seen - d0), 2);
        chk("s4_wdata_beats", 32'(wdata_bad), 0);
        chk("s4_err_cnt", 32'(err_cnt), 0);
        chk("s4_busy_idle", 32'(busy), 0);

        // misplaced rlast
        clear_logs(); d0 = done_seen; bad_rlast = 1;
        start_run();
        wait_done(d0 + 1, "s5_done_timeout");
        settle();
        bad_rlast = 0;
        chk("s5_proto_err", 32'(proto_err), 1);
        chk("s5_r_beats", 32'(r_beats), 8);
        chk("s5_err_cnt", 32'(err_cnt), 0);
        clear_logs(); d0 = done_seen;
        start_run();
        chk("s5_proto_clr", 32'(proto_err), 0);
        wait_done(d0 + 1, "s5b_done_timeout");
        settle();
        chk("s5b_proto_err", 32'(proto_err), 0);

        // reset in the middle of a write burst
        clear_logs();
        start_run();
        n = 0;
        while (w_hs < 2 && n < 500) begin
            @(posedge aclk);
            #2;
            n++;
        end
        chk("s6_w_beats_reached", 32'(w_hs >= 2), 1);
        chk("s6_in_write", 32'(wvalid), 1);
        areset = 1;
        @(posedge aclk);
        #2;
        chk("s6_awvalid", 32'(awvalid), 0);
        chk("s6_wvalid", 32'(wvalid), 0);
        chk("s6_arvalid", 32'(arvalid), 0);
        chk("s6_bready", 32'(bready), 0);
        chk("s6_rready", 32'(rready), 0);
        chk("s6_busy", 32'(busy), 0);
        chk("s6_pass_cnt", 32'(pass_cnt), 0);
        chk("s6_err_cnt", 32'(err_cnt), 0);
        chk("s6_wdata", 32'(wdata), 0);
        areset = 0;
        @(posedge aclk);
        #2;
        clear_logs(); d0 = done_seen;
        start_run();
        wait_done(d0 + 1, "s6b_done_timeout");
        settle();
        chk("s6b_err_cnt", 32'(err_cnt), 0);
        chk("s6b_proto_err", 32'(proto_err), 0);
        chk("s6b_pass_cnt", 32'(pass_cnt), 1);
        chk("s6b_wdata_beats", 32'(wdata_bad), 0);
        chk("s6b_wdata_a2", 32'(w2_v[0]), 32'hA5A7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/axi4_mem_tester.md
Name: axi4_mem_tester

Overview:
- Self-checking meta-AXI4 master that sits directly upstream of ddr_sdram_ctrl; it is a drop-in alternative to the UART bridge.
- Writes a deterministic address-derived pattern over a burst-aligned region, then reads the region back and compares every beat.
- Reports per-run error count, first failing address, protocol errors and pass count.
- Optional loop mode repeats the test with the pattern inverted on alternate passes.

Parameters:
- A_WIDTH, 25, byte address width; matches the controller.
- D_WIDTH, 16, data width in bits; a multiple of 8.
- BURST_LEN, 8'd15, value driven on awlen/arlen; the burst has BURST_LEN+1 beats.
- BASE_ADDR, 0, byte address of the first burst; must be aligned to STEP.
- NUM_BURSTS, 16, number of bursts per pass; minimum 1.
- SEED, all-ones pattern, D_WIDTH-bit XOR seed.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- start  in  1  begins a run when idle.
- loop  in  1  sampled at end of pass; 1 = continue.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of each pass.
- pass_cnt  out  16  completed passes; wraps.
- err_cnt  out  16  data mismatches; saturates at 16'hFFFF.
- first_err_addr  out  A_WIDTH  byte address of the first mismatch in the run.
- proto_err  out  1  sticky rlast violation.
- awvalid out 1; awready in 1; awaddr out A_WIDTH; awlen out 8.
- wvalid out 1; wready in 1; wlast out 1; wdata out D_WIDTH.
- bvalid in 1; bready out 1.
- arvalid out 1; arready in 1; araddr out A_WIDTH; arlen out 8.
- rvalid in 1; rready out 1; rlast in 1; rdata in D_WIDTH.

Behaviour:
- Reset values: all valids, bready, rready, busy, done and proto_err are 0. Counters, addresses and wdata are 0. awlen/arlen are constant BURST_LEN.
- Constants:
  - STEP = (BURST_LEN+1)*D_WIDTH/8.
  - Burst k address = BASE_ADDR + k*STEP, computed modulo 2^A_WIDTH (wraps silently).
  - Beat j address = burst address + j*D_WIDTH/8.
- Pattern for beat address a: zero-extend or truncate a to D_WIDTH, then XOR with SEED. Invert when pass_cnt[0]=1.
- State machine: IDLE -> AW -> W -> B -> (next burst: AW | last: AR) -> R -> (next burst: AR | last: END) -> IDLE or AW.
- IDLE:
  - start=1 clears err_cnt, first_err_addr and proto_err; pass_cnt is not cleared.
  - Sets busy=1, burst index 0, then goes to AW.
  - start is ignored outside IDLE.
- AW:
  - awvalid=1 and awaddr held stable until awready is sampled high. Then go to W.
  - No write data is sent before the address is accepted.
- W:
  - wvalid=1; wdata and wlast are held while wready=0.
  - Beat advances on wvalid&&wready.
  - wlast=1 only on beat BURST_LEN; after that beat's handshake go to B.
- B:
  - bready=1; leave on bvalid.
  - After burst NUM_BURSTS-1, burst index resets to 0 and the state goes to AR.
- AR: arvalid/araddr held until arready, then go to R.
- R, with rready=1, on each rvalid:
  - Compare rdata with the expected pattern.
  - On mismatch, err_cnt++ (saturating); the first mismatch in the run latches the beat address into first_err_addr.
  - rlast=1 on a beat other than BURST_LEN, or rlast=0 on beat BURST_LEN, sets proto_err.
  - The burst ends on beat BURST_LEN regardless of rlast.
- END (one cycle): done=1, pass_cnt++.
  - If loop=1: stay busy, go to AW, burst index 0; the pattern inverts.
  - Else: busy=0, go to IDLE.
- Only one outstanding transaction at a time; reads never overlap writes.
- areset mid-operation: all outputs return to reset values on the next edge and any in-flight burst is abandoned. The controller is reset together with this block.

Decomposition:
- Package axi4_mem_tester_pkg holds:
  - state enum (IDLE, AW, W, B, AR, R, END);
  - function pattern(addr, invert) returning D_WIDTH bits;
  - function STEP.
- No sub-module; the datapath and FSM are small enough for a single module.

Test Plan:
All cases use D_WIDTH=16, BURST_LEN=3, NUM_BURSTS=2, BASE_ADDR=0, SEED=16'hA5A5, with an ideal memory model that is always ready.
- Single pass: start pulse -> awaddr 0 then 8; wdata at addr 2 = 16'hA5A7, wlast on 4th beat; araddr 0, 8; done pulse; err_cnt=0, pass_cnt=1, proto_err=0.
- Fault injection: memory corrupts the read at addr 10 to 16'h0000 -> err_cnt=1, first_err_addr=10; a further fault at addr 12 gives err_cnt=2, first_err_addr still 10.
- Backpressure: random awready/wready/arready/bvalid stalls of 0-5 cycles -> wdata/awaddr stable while stalled; results identical to the first scenario.
- Loop: loop=1 for two passes -> pass-1 wdata at addr 2 = 16'h5A58; pass_cnt=2; busy stays 1 between passes; done pulses twice.
- Protocol: memory asserts rlast on beat 1 -> proto_err=1 (sticky), burst still consumes 4 beats, next start clears it.
- Reset mid-W (after beat 1) -> next cycle all valids 0, busy 0, counters 0; a subsequent start completes a clean pass.
